// File: rtl/cgram_ctrl.sv
// ---------------------------------------------------------------------------
// cgram_ctrl -- palette RAM (CGRAM) controller
//
// Wraps an inferred word RAM and adds the SNES-style CPU register interface:
// a word-address latch, a shared low/high byte flip-flop, two-byte write
// assembly, auto-increment and byte readback. After reset an optional clear
// sequencer zeroes every word. A separate registered read port feeds the PPU
// colour pipeline.
//
// Parameters:
//   DATA_W     stored word width (9..16)
//   ADDR_W     word address width, depth = 2**ADDR_W
//   INIT_CLEAR 1 = zero all words after reset, 0 = skip the clear
//
// Optional feature macro: CGRAM_FWD_EN
//   defined   : PPU port is write-first (forwards the word committed this cycle)
//   undefined : PPU port is read-first
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   busy                 high while the post-reset clear runs
//   cpu_addr_we/cpu_addr load word address ($2121), clears flip
//   cpu_data_we/cpu_wdata byte write ($2122)
//   cpu_rd/cpu_obus      byte read ($213B), open-bus fill for missing bits
//   cpu_rdata            read byte, valid the cycle after cpu_rd, else held
//   ppu_rd/ppu_addr      PPU read request
//   ppu_dout             PPU word, valid the cycle after ppu_rd, else held
// ---------------------------------------------------------------------------
module cgram_ctrl #(
    parameter int DATA_W     = 15,
    parameter int ADDR_W     = 8,
    parameter int INIT_CLEAR = 1
) (
    input  logic              clk,
    input  logic              resetn,
    output logic              busy,
    input  logic              cpu_addr_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_data_we,
    input  logic [7:0]        cpu_wdata,
    input  logic              cpu_rd,
    input  logic [7:0]        cpu_obus,
    output logic [7:0]        cpu_rdata,
    input  logic              ppu_rd,
    input  logic [ADDR_W-1:0] ppu_addr,
    output logic [DATA_W-1:0] ppu_dout
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    typedef enum logic {ST_INIT, ST_IDLE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] clr_cnt;
    logic              flip;
    logic [7:0]        lo_latch;

    logic [DATA_W-1:0] mem [DEPTH];

    // Single write port, shared by the clear sequencer and the CPU
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] cpu_word;
    logic [7:0]        hi_byte;
    logic [DATA_W-1:0] ppu_next;

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr;
        mem_wdata = {cpu_wdata[DATA_W-9:0], lo_latch};
        if (state == ST_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt;
            mem_wdata = '0;
        end else if (!cpu_addr_we && cpu_data_we && flip) begin
            // Second byte commits the word; address strobe wins if coincident
            mem_we = 1'b1;
        end
    end

    assign cpu_word = mem[addr];

    // High-byte readback: bits above the stored word come from open bus
    generate
        if (DATA_W < 16) begin : g_obus_fill
            assign hi_byte = {cpu_obus[7:DATA_W-8], cpu_word[DATA_W-1:8]};
        end else begin : g_full_word
            assign hi_byte = cpu_word[15:8];
        end
    endgenerate

`ifdef CGRAM_FWD_EN
    // Write-first: a PPU read of the word being committed sees the new value
    assign ppu_next = (mem_we && (ppu_addr == mem_waddr)) ? mem_wdata : mem[ppu_addr];
`else
    assign ppu_next = mem[ppu_addr];
`endif

    // NOTE: the RAM array has no reset so it maps onto block RAM; the clear
    // sequencer zeroes it instead when INIT_CLEAR is set.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= (INIT_CLEAR != 0) ? ST_INIT : ST_IDLE;
            busy      <= (INIT_CLEAR != 0);
            clr_cnt   <= '0;
            addr      <= '0;
            flip      <= 1'b0;
            lo_latch  <= 8'h00;
            cpu_rdata <= 8'h00;
        end else begin
            case (state)
                ST_INIT: begin
                    // CPU strobes are dropped while clearing
                    clr_cnt <= clr_cnt + ADDR_ONE;
                    if (clr_cnt == '1) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (cpu_addr_we) begin
                        addr <= cpu_addr;
                        flip <= 1'b0;
                    end else if (cpu_data_we) begin
                        if (!flip) begin
                            lo_latch <= cpu_wdata;
                            flip     <= 1'b1;
                        end else begin
                            addr <= addr + ADDR_ONE;
                            flip <= 1'b0;
                        end
                    end else if (cpu_rd) begin
                        if (!flip) begin
                            cpu_rdata <= cpu_word[7:0];
                            flip      <= 1'b1;
                        end else begin
                            cpu_rdata <= hi_byte;
                            addr      <= addr + ADDR_ONE;
                            flip      <= 1'b0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // PPU port: independent of CPU activity, holds when not reading
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ppu_dout <= '0;
        end else if (ppu_rd) begin
            ppu_dout <= ppu_next;
        end
    end

endmodule

// File: tb/tb_cgram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cgram_ctrl -- directed self-checking bench for cgram_ctrl
// (DATA_W = 15, ADDR_W = 8, INIT_CLEAR = 1). Inputs change 1 time unit after
// a rising edge; outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_cgram_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        busy;
    logic        cpu_addr_we;
    logic [7:0]  cpu_addr;
    logic        cpu_data_we;
    logic [7:0]  cpu_wdata;
    logic        cpu_rd;
    logic [7:0]  cpu_obus;
    logic [7:0]  cpu_rdata;
    logic        ppu_rd;
    logic [7:0]  ppu_addr;
    logic [14:0] ppu_dout;

    int total = 0;
    int bad   = 0;
    int cnt;

`ifdef CGRAM_FWD_EN
    localparam logic [15:0] FWD_EXP = 16'h1234;
`else
    localparam logic [15:0] FWD_EXP = 16'h0000;
`endif

    cgram_ctrl #(.DATA_W(15), .ADDR_W(8), .INIT_CLEAR(1)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .busy        (busy),
        .cpu_addr_we (cpu_addr_we),
        .cpu_addr    (cpu_addr),
        .cpu_data_we (cpu_data_we),
        .cpu_wdata   (cpu_wdata),
        .cpu_rd      (cpu_rd),
        .cpu_obus    (cpu_obus),
        .cpu_rdata   (cpu_rdata),
        .ppu_rd      (ppu_rd),
        .ppu_addr    (ppu_addr),
        .ppu_dout    (ppu_dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge, then drop all strobes
    task automatic tick();
        @(posedge clk);
        #1;
        cpu_addr_we = 1'b0;
        cpu_data_we = 1'b0;
        cpu_rd      = 1'b0;
        ppu_rd      = 1'b0;
    endtask

    task automatic addr_wr(input logic [7:0] a);
        cpu_addr_we = 1'b1;
        cpu_addr    = a;
        tick();
    endtask

    task automatic data_wr(input logic [7:0] d);
        cpu_data_we = 1'b1;
        cpu_wdata   = d;
        tick();
    endtask

    task automatic cpu_read(input logic [7:0] obus, input logic [7:0] exp, input string tag);
        cpu_rd   = 1'b1;
        cpu_obus = obus;
        tick();
        check(tag, {8'h00, cpu_rdata}, {8'h00, exp});
    endtask

    task automatic ppu_chk(input logic [7:0] a, input logic [15:0] exp, input string tag);
        ppu_rd   = 1'b1;
        ppu_addr = a;
        tick();
        check(tag, {1'b0, ppu_dout}, exp);
    endtask

    initial begin
        resetn      = 1'b0;
        cpu_addr_we = 1'b0;
        cpu_addr    = 8'h00;
        cpu_data_we = 1'b0;
        cpu_wdata   = 8'h00;
        cpu_rd      = 1'b0;
        cpu_obus    = 8'h00;
        ppu_rd      = 1'b0;
        ppu_addr    = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {15'd0, busy}, 16'h0001);
        check("rst_rdata", {8'h00, cpu_rdata}, 16'h0000);
        check("rst_ppu", {1'b0, ppu_dout}, 16'h0000);
        resetn = 1'b1;

        // Strobes during the clear are dropped
        cnt = 0;
        cpu_rd   = 1'b1;
        cpu_obus = 8'hFF;
        tick(); cnt++;
        check("init_rd_drop", {8'h00, cpu_rdata}, 16'h0000);
        addr_wr(8'h40); cnt++;
        data_wr(8'h99); cnt++;
        while (busy && cnt < 1000) begin
            tick(); cnt++;
        end
        check("busy_cycles", cnt[15:0], 16'd256);
        check("busy_low", {15'd0, busy}, 16'h0000);

        // Cleared words
        ppu_chk(8'h00, 16'h0000, "clr_00");
        ppu_chk(8'h7F, 16'h0000, "clr_7f");
        ppu_chk(8'hFF, 16'h0000, "clr_ff");

        // Address stayed 0 and flip stayed 0 through the clear
        data_wr(8'hAA);
        data_wr(8'h3B);
        ppu_chk(8'h00, 16'h3BAA, "init_addr_drop");
        ppu_chk(8'h40, 16'h0000, "init_data_drop");

        // Basic two-byte write
        addr_wr(8'h10);
        data_wr(8'h1F);
        data_wr(8'h7C);
        ppu_chk(8'h10, 16'h7C1F, "wr_7c1f");
        ppu_addr = 8'h55;
        tick();
        check("ppu_hold", {1'b0, ppu_dout}, 16'h7C1F);

        // Byte readback, high byte filled from open bus
        addr_wr(8'h10);
        cpu_read(8'hA5, 8'h1F, "rd_lo");
        cpu_read(8'hA5, 8'hFC, "rd_hi");
        tick();
        check("rdata_hold", {8'h00, cpu_rdata}, 16'h00FC);
        // Address advanced to 0x11
        data_wr(8'h77);
        data_wr(8'h00);
        ppu_chk(8'h11, 16'h0077, "rd_incr");

        // Address wrap
        addr_wr(8'hFF);
        data_wr(8'h01);
        data_wr(8'h02);
        data_wr(8'h03);
        data_wr(8'h04);
        ppu_chk(8'hFF, 16'h0201, "wrap_ff");
        ppu_chk(8'h00, 16'h0403, "wrap_00");
        data_wr(8'h0A);
        data_wr(8'h0B);
        ppu_chk(8'h01, 16'h0B0A, "wrap_flip0");

        // Coincident addr_we and data_we with flip = 1
        addr_wr(8'h50);
        data_wr(8'h11);
        cpu_addr_we = 1'b1;
        cpu_addr    = 8'h20;
        cpu_data_we = 1'b1;
        cpu_wdata   = 8'h55;
        tick();
        ppu_chk(8'h50, 16'h0000, "prio_no_wr");
        data_wr(8'h66);
        data_wr(8'h05);
        ppu_chk(8'h20, 16'h0566, "prio_addr");
        ppu_chk(8'h21, 16'h0000, "prio_flip");

        // Same-cycle PPU read of the word being committed
        addr_wr(8'h30);
        data_wr(8'h34);
        cpu_data_we = 1'b1;
        cpu_wdata   = 8'h12;
        ppu_rd      = 1'b1;
        ppu_addr    = 8'h30;
        tick();
        check("ppu_same_cycle", {1'b0, ppu_dout}, FWD_EXP);
        ppu_chk(8'h30, 16'h1234, "ppu_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cgram_ctrl.md
Name: cgram_ctrl

Overview:
Parametrised palette-RAM controller; successor to the fixed 256x15 dual-port CGRAM macro. It wraps an inferred dual-port word RAM and adds the SNES-style CPU register interface: word-address latch, low/high byte flip-flop, write assembly, auto-increment and byte readback. It also provides a post-reset clear sequencer and a registered PPU read port. It sits between the PPU register decoder ($2121/$2122/$213B) and the PPU colour pipeline.

Parameters:
DATA_W, 15, stored word width; legal range 9..16.
ADDR_W, 8, word address width; depth = 2**ADDR_W.
INIT_CLEAR, 1, 1 = clear all words after reset; 0 = skip the clear and leave RAM contents undefined.

Ports:
clk  in  1  system clock; all logic on rising edge
resetn  in  1  asynchronous, active-low reset
busy  out  1  high while the clear sequence runs
cpu_addr_we  in  1  strobe: load word address ($2121)
cpu_addr  in  ADDR_W  word address value
cpu_data_we  in  1  strobe: byte write ($2122)
cpu_wdata  in  8  write byte
cpu_rd  in  1  strobe: byte read ($213B)
cpu_obus  in  8  open-bus byte; fills unimplemented high bits
cpu_rdata  out  8  read byte; valid the cycle after cpu_rd
ppu_rd  in  1  PPU read enable
ppu_addr  in  ADDR_W  PPU word address
ppu_dout  out  DATA_W  PPU data; valid the cycle after ppu_rd, held otherwise

Behaviour:
- Reset (resetn low, asynchronous): word address = 0, flip = 0, low latch = 0, cpu_rdata = 0, ppu_dout = 0. busy = 1 if INIT_CLEAR, else 0. State = INIT if INIT_CLEAR, else IDLE.
- FSM has two states: INIT and IDLE.
  - INIT: one word per cycle is written with 0 via the CPU port, counter 0..2**ADDR_W-1. After the last word: busy = 0 and state = IDLE. Clear takes 2**ADDR_W cycles from reset release.
  - During INIT: all cpu_* strobes are dropped, with no state change. ppu_rd still loads ppu_dout, but the value is 0 or a just-cleared word.
- Address write: cpu_addr_we loads the word address and clears flip.
- Data write, flip = 0: latch cpu_wdata; flip = 1.
- Data write, flip = 1:
  - mem[addr] = {cpu_wdata[DATA_W-9:0], latch}.
  - Upper bits of cpu_wdata are discarded.
  - addr increments; flip = 0.
- Read, flip = 0: cpu_rdata = mem[addr][7:0]; flip = 1.
- Read, flip = 1:
  - cpu_rdata = {cpu_obus[7:DATA_W-8], mem[addr][DATA_W-1:8]} when DATA_W < 16.
  - cpu_rdata = mem[addr][15:8] when DATA_W = 16.
  - addr increments; flip = 0.
  - cpu_obus is sampled in the cycle of cpu_rd.
- Reads and writes share one flip-flop, so a mixed sequence interleaves as the register interface defines.
- Address wraps from 2**ADDR_W-1 to 0. No overflow flag.
- Priority when strobes coincide: cpu_addr_we > cpu_data_we > cpu_rd. Lower-priority strobes in the same cycle are ignored completely.
- cpu_rdata holds its last value when no read occurs.
- PPU port: 1-cycle registered read, independent of CPU activity. ppu_dout holds when ppu_rd = 0.
- PPU read of the address being written in the same cycle returns the OLD word (read-first), unless the feature below is enabled.
- CPU read latency is 1 cycle.

Optional Feature:
CGRAM_FWD_EN
- Defined: the PPU port is write-first. When ppu_rd is high and ppu_addr equals the word being committed in that cycle (second-byte write only), ppu_dout takes the newly assembled word the next cycle. This also applies to INIT clear writes, which forward 0.
- Undefined: read-first, as in Behaviour. No forwarding mux is present.

Test Plan:
- Reset release, INIT_CLEAR = 1, ADDR_W = 8 -> busy high for exactly 256 cycles. Then a ppu_rd of addresses 0x00, 0x7F and 0xFF each returns 0x0000.
- addr_we 0x10; data_we 0x1F; data_we 0x7C -> mem[0x10] = 0x7C1F, addr = 0x11. PPU read of 0x10 returns 0x7C1F one cycle later.
- After the above: addr_we 0x10, cpu_obus = 0xA5; rd; rd -> cpu_rdata = 0x1F, then 0xFC (bit7 from obus = 1, high bits 0x7C). addr = 0x11.
- addr_we 0xFF; write bytes 0x01, 0x02, then 0x03, 0x04 -> mem[0xFF] = 0x0201, mem[0x00] = 0x0403 (wrap); flip = 0.
- With flip = 1, assert addr_we 0x20 and data_we 0x55 in the same cycle -> addr = 0x20, flip = 0, no memory write. cpu_rd during INIT -> cpu_rdata is unchanged.
- Second-byte write to 0x30 = 0x1234 with ppu_rd at 0x30 (old value 0x0000) in the same cycle -> ppu_dout = 0x0000 without CGRAM_FWD_EN, 0x1234 with it.
